ifetch_axil: RTL and testbench

IFETCH_AXIL -- requirements
Module: ifetch_axil

---
 rtl/ifetch_axil.sv | 97 +++++++++
 tb/tb_ifetch_axil.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch_axil.sv
// Instruction fetch unit with an AXI4-lite read master: one outstanding read, held until decode accepts it.
// Optional IFETCH_ERR_NOP_EN: error responses substitute NOP_INSTR and raise fetch_err.
module ifetch_axil #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_load,
    input  logic [31:0] pc_next,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic        fetch_err,
    output logic [31:0] m_araddr,
    output logic [2:0]  m_arprot,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic        rd_done;
    logic        issue_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = ADDR;
            ADDR:    if (m_arready)   state_nxt = DATA;
            DATA:    if (m_rvalid)    state_nxt = HOLD;
            HOLD:    if (instr_ready) state_nxt = ADDR;
            default: state_nxt = IDLE;
        endcase
    end

    assign m_arvalid   = (state == ADDR);
    assign m_rready    = (state == DATA);
    assign instr_valid = (state == HOLD);
    assign m_araddr    = {pc[31:2], 2'b00};
    assign m_arprot    = 3'b100;

    assign rd_done    = (state == DATA) && m_rvalid;
    assign issue_next = (state == HOLD) && instr_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            instr  <= '0;
            pc_out <= RESET_PC;
        end else begin
            if (rd_done) begin
                pc_out <= pc;
`ifdef IFETCH_ERR_NOP_EN
                instr  <= m_rresp[1] ? NOP_INSTR : m_rdata;
`else
                instr  <= m_rdata;
`endif
            end
            // pc only moves on leaving HOLD, so pc_out == pc while an instruction is presented
            if (issue_next) begin
                pc <= pc_load ? (pc_next & 32'hFFFF_FFFC) : pc + 32'd4;
            end
        end
    end

`ifdef IFETCH_ERR_NOP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_err <= 1'b0;
        end else if (rd_done) begin
            fetch_err <= m_rresp[1];
        end
    end
`else
    logic unused_rresp;
    assign unused_rresp = ^{m_rresp, NOP_INSTR};
    assign fetch_err    = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_axil.sv
// Directed self-checking bench for ifetch_axil: table of fetches plus stall/reset sequences.
module tb_ifetch_axil;

`ifdef IFETCH_ERR_NOP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_load;
    logic [31:0] pc_next;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        fetch_err;
    logic [31:0] m_araddr;
    logic [2:0]  m_arprot;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;

    int n_checks = 0;
    int n_fail   = 0;

    ifetch_axil #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .pc_load(pc_load), .pc_next(pc_next),
        .instr_ready(instr_ready), .instr_valid(instr_valid), .instr(instr),
        .pc_out(pc_out), .fetch_err(fetch_err), .m_araddr(m_araddr),
        .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pc_load;
        logic [31:0] pc_next;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_arvalid();
        int n = 0;
        while (!m_arvalid && n < 20) begin
            step();
            n++;
        end
        check("arvalid_seen", {31'b0, m_arvalid}, 32'd1);
    endtask

    task automatic wait_ivalid();
        int n = 0;
        while (!instr_valid && n < 20) begin
            step();
            n++;
        end
        check("instr_valid_seen", {31'b0, instr_valid}, 32'd1);
    endtask

    initial begin
        logic [31:0] exp_instr;
        logic        exp_err;
        logic [31:0] held_instr;
        logic [31:0] addr_a;

        vecs[0] = '{1'b0, 32'h0000_0000, 32'h0000_0093, 2'b00, 32'h0000_0000};
        vecs[1] = '{1'b1, 32'h0000_0102, 32'h1234_5678, 2'b00, 32'h0000_0004};
        vecs[2] = '{1'b1, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 2'b10, 32'h0000_0100};
        vecs[3] = '{1'b0, 32'h0000_0000, 32'hA5A5_5A5A, 2'b00, 32'hFFFF_FFFC};
        vecs[4] = '{1'b1, 32'h0000_0041, 32'hCAFE_F00D, 2'b11, 32'h0000_0000};
        vecs[5] = '{1'b0, 32'h0000_0000, 32'h0000_0513, 2'b01, 32'h0000_0040};
        vecs[6] = '{1'b1, 32'h0000_2003, 32'h00C5_8593, 2'b00, 32'h0000_0044};

        reset = 1'b1; pc_load = 1'b0; pc_next = '0; instr_ready = 1'b1;
        m_arready = 1'b1; m_rdata = '0; m_rresp = 2'b00; m_rvalid = 1'b1;
        step();
        step();
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_arvalid", {31'b0, m_arvalid}, 32'd0);
        check("rst_rready", {31'b0, m_rready}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
        check("rst_araddr", m_araddr, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            m_rdata = vecs[i].rdata;
            m_rresp = vecs[i].rresp;
            wait_arvalid();
            check($sformatf("v%0d_araddr", i), m_araddr, vecs[i].exp_addr);
            check($sformatf("v%0d_arprot", i), {29'b0, m_arprot}, 32'd4);
            wait_ivalid();
            exp_err   = ERR_EN && vecs[i].rresp[1];
            exp_instr = exp_err ? NOP : vecs[i].rdata;
            check($sformatf("v%0d_instr", i), instr, exp_instr);
            check($sformatf("v%0d_pc_out", i), pc_out, vecs[i].exp_addr);
            check($sformatf("v%0d_fetch_err", i), {31'b0, fetch_err}, {31'b0, exp_err});
            pc_load = vecs[i].pc_load;
            pc_next = vecs[i].pc_next;
        end

        // AR stall with a stray read response present: nothing may be accepted
        addr_a    = 32'h0000_2000;
        m_arready = 1'b0;
        m_rvalid  = 1'b1;
        m_rdata   = 32'hBAD0_0000;
        m_rresp   = 2'b00;
        step();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d_arvalid", i), {31'b0, m_arvalid}, 32'd1);
            check($sformatf("stall%0d_araddr", i), m_araddr, addr_a);
            check($sformatf("stall%0d_rready", i), {31'b0, m_rready}, 32'd0);
            check($sformatf("stall%0d_ivalid", i), {31'b0, instr_valid}, 32'd0);
            step();
        end
        m_arready = 1'b1;
        m_rvalid  = 1'b0;
        step();
        check("data_rready", {31'b0, m_rready}, 32'd1);
        check("data_arvalid", {31'b0, m_arvalid}, 32'd0);
        step();
        check("data_wait_rready", {31'b0, m_rready}, 32'd1);
        check("data_wait_ivalid", {31'b0, instr_valid}, 32'd0);
        m_rvalid = 1'b1;
        m_rdata  = 32'h0051_8533;
        step();
        check("late_r_ivalid", {31'b0, instr_valid}, 32'd1);
        check("late_r_instr", instr, 32'h0051_8533);
        check("late_r_pc_out", pc_out, addr_a);

        // Decode back-pressure: output must hold and no new fetch may issue
        instr_ready = 1'b0;
        held_instr  = instr;
        m_rdata     = 32'h7777_7777;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("hold%0d_ivalid", i), {31'b0, instr_valid}, 32'd1);
            check($sformatf("hold%0d_instr", i), instr, held_instr);
            check($sformatf("hold%0d_pc_out", i), pc_out, addr_a);
            check($sformatf("hold%0d_arvalid", i), {31'b0, m_arvalid}, 32'd0);
        end
        pc_load     = 1'b1;
        pc_next     = 32'h0000_0102;
        instr_ready = 1'b1;
        step();
        check("branch_arvalid", {31'b0, m_arvalid}, 32'd1);
        check("branch_araddr", m_araddr, 32'h0000_0100);

        // Reset in DATA, colliding with a valid read response
        m_rvalid = 1'b0;
        step();
        check("pre_rst_rready", {31'b0, m_rready}, 32'd1);
        reset    = 1'b1;
        m_rvalid = 1'b1;
        step();
        check("mid_rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("mid_rst_arvalid", {31'b0, m_arvalid}, 32'd0);
        check("mid_rst_rready", {31'b0, m_rready}, 32'd0);
        check("mid_rst_instr", instr, 32'h0);
        check("mid_rst_pc_out", pc_out, 32'h0);
        check("mid_rst_fetch_err", {31'b0, fetch_err}, 32'd0);
        reset   = 1'b0;
        m_rdata = 32'h0000_0093;
        wait_arvalid();
        check("post_rst_araddr", m_araddr, 32'h0);
        wait_ivalid();
        check("post_rst_instr", instr, 32'h0000_0093);
        check("post_rst_pc_out", pc_out, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
